hazard_scoreboard: RTL and testbench

- Central hazard controller for the in-order pipeline: tracks in-flight register writes per architectural register, decides each cycle whether the decode-stage instruction may issue, and picks the operand source (register file, EXE, MEM or WB bypass) for each source operand.
- Sits beside decode_stage and replaces its local compare-based stall, driving its stall and operand-mux controls.
- Receives issue, bypass and writeback events from the pipeline, plus a flush.

---
 rtl/hazard_scoreboard_pkg.sv | 25 ++
 rtl/hazard_scoreboard_if.sv | 58 +++++
 rtl/hazard_scoreboard_src_resolve.sv | 45 ++++
 rtl/hazard_scoreboard.sv | 123 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard scoreboard: operand-forwarding
// select encoding and the decode-stage issue bundle.
package hazard_scoreboard_pkg;

    localparam int unsigned REG_FILE_LEN = 32;
    localparam int unsigned REG_IDX_W    = $clog2(REG_FILE_LEN);

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EXE = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_t;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] src1;
        logic                 src1_used;
        logic [REG_IDX_W-1:0] src2;
        logic                 src2_used;
        logic [REG_IDX_W-1:0] dst;
        logic                 writes;
    } sb_issue_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side bundle for the hazard scoreboard: decode request, EXE/MEM/WB
// producer status, flush, and the stall/issue/forwarding decisions.
interface hazard_scoreboard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned REG_FILE_LEN = hazard_scoreboard_pkg::REG_FILE_LEN
);
    localparam int unsigned IDX_W = $clog2(REG_FILE_LEN);

    logic                    dec_valid;
    logic [IDX_W-1:0]        dec_src1;
    logic [IDX_W-1:0]        dec_src2;
    logic                    dec_src1_used;
    logic                    dec_src2_used;
    logic [IDX_W-1:0]        dec_dst;
    logic                    dec_writes;

    logic                    exe_valid;
    logic                    exe_wen;
    logic                    exe_ready;
    logic [IDX_W-1:0]        exe_dst;

    logic                    mem_valid;
    logic                    mem_wen;
    logic                    mem_ready;
    logic [IDX_W-1:0]        mem_dst;

    logic                    wb_valid;
    logic [IDX_W-1:0]        wb_dst;

    logic                    flush;

    logic                    stall_out;
    logic                    issue_out;
    fwd_sel_t                sel_src1;
    fwd_sel_t                sel_src2;
    logic [REG_FILE_LEN-1:0] busy_mask;
    logic                    err_out;

    modport master (
        output dec_valid, dec_src1, dec_src2, dec_src1_used, dec_src2_used,
               dec_dst, dec_writes,
               exe_valid, exe_wen, exe_ready, exe_dst,
               mem_valid, mem_wen, mem_ready, mem_dst,
               wb_valid, wb_dst, flush,
        input  stall_out, issue_out, sel_src1, sel_src2, busy_mask, err_out
    );

    modport slave (
        input  dec_valid, dec_src1, dec_src2, dec_src1_used, dec_src2_used,
               dec_dst, dec_writes,
               exe_valid, exe_wen, exe_ready, exe_dst,
               mem_valid, mem_wen, mem_ready, mem_dst,
               wb_valid, wb_dst, flush,
        output stall_out, issue_out, sel_src1, sel_src2, busy_mask, err_out
    );

endinterface

// File: rtl/hazard_scoreboard_src_resolve.sv
// Combinational operand-source resolution for one decode source register:
// picks RF or the youngest bypassable producer, or flags the source blocked.
module scoreboard_src_resolve
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned IDX_W = hazard_scoreboard_pkg::REG_IDX_W,
    parameter int unsigned CNT_W = 2
) (
    input  logic [IDX_W-1:0] src,
    input  logic             used,
    input  logic [CNT_W-1:0] cnt,
    input  logic             exe_valid,
    input  logic             exe_wen,
    input  logic             exe_ready,
    input  logic [IDX_W-1:0] exe_dst,
    input  logic             mem_valid,
    input  logic             mem_wen,
    input  logic             mem_ready,
    input  logic [IDX_W-1:0] mem_dst,
    input  logic             wb_valid,
    input  logic [IDX_W-1:0] wb_dst,
    output fwd_sel_t         sel,
    output logic             blocked
);

    always_comb begin
        sel     = FWD_RF;
        blocked = 1'b0;
        // Stage checks run youngest-first so the most recent producer wins.
        if (used && (src != '0) && (cnt != '0)) begin
            if (exe_valid && exe_wen && (exe_dst == src)) begin
                if (exe_ready) sel = FWD_EXE;
                else           blocked = 1'b1;
            end else if (mem_valid && mem_wen && (mem_dst == src)) begin
                if (mem_ready) sel = FWD_MEM;
                else           blocked = 1'b1;
            end else if (wb_valid && (wb_dst == src)) begin
                sel = FWD_WB;
            end else begin
                blocked = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Central hazard controller: per-register pending-write counters, issue/stall
// decision and operand forwarding selects for the decode-stage instruction.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned REG_FILE_LEN = hazard_scoreboard_pkg::REG_FILE_LEN,
    parameter int unsigned CNT_W        = 2
) (
    input  logic          clk,
    input  logic          rst,
    hazard_scoreboard_if.slave sb
);

    localparam int unsigned IDX_W = $clog2(REG_FILE_LEN);

    logic [CNT_W-1:0]        cnt [REG_FILE_LEN];
    logic [REG_FILE_LEN-1:0] inc_vec;
    logic [REG_FILE_LEN-1:0] dec_vec;
    logic                    err;
    sb_issue_t               dec;
    fwd_sel_t                sel1;
    fwd_sel_t                sel2;
    logic                    blk1;
    logic                    blk2;
    logic                    struct_stall;
    logic                    stall;
    logic                    issue;

    assign dec = '{valid:     sb.dec_valid,
                   src1:      sb.dec_src1,
                   src1_used: sb.dec_src1_used,
                   src2:      sb.dec_src2,
                   src2_used: sb.dec_src2_used,
                   dst:       sb.dec_dst,
                   writes:    sb.dec_writes};

    scoreboard_src_resolve #(.IDX_W(IDX_W), .CNT_W(CNT_W)) u_src1 (
        .src       (dec.src1),
        .used      (dec.src1_used),
        .cnt       (cnt[dec.src1]),
        .exe_valid (sb.exe_valid),
        .exe_wen   (sb.exe_wen),
        .exe_ready (sb.exe_ready),
        .exe_dst   (sb.exe_dst),
        .mem_valid (sb.mem_valid),
        .mem_wen   (sb.mem_wen),
        .mem_ready (sb.mem_ready),
        .mem_dst   (sb.mem_dst),
        .wb_valid  (sb.wb_valid),
        .wb_dst    (sb.wb_dst),
        .sel       (sel1),
        .blocked   (blk1)
    );

    scoreboard_src_resolve #(.IDX_W(IDX_W), .CNT_W(CNT_W)) u_src2 (
        .src       (dec.src2),
        .used      (dec.src2_used),
        .cnt       (cnt[dec.src2]),
        .exe_valid (sb.exe_valid),
        .exe_wen   (sb.exe_wen),
        .exe_ready (sb.exe_ready),
        .exe_dst   (sb.exe_dst),
        .mem_valid (sb.mem_valid),
        .mem_wen   (sb.mem_wen),
        .mem_ready (sb.mem_ready),
        .mem_dst   (sb.mem_dst),
        .wb_valid  (sb.wb_valid),
        .wb_dst    (sb.wb_dst),
        .sel       (sel2),
        .blocked   (blk2)
    );

    // A saturated counter cannot absorb another in-flight write.
    assign struct_stall = dec.writes && (dec.dst != '0) && (cnt[dec.dst] == '1);
    assign stall        = dec.valid && (blk1 || blk2 || struct_stall) && !sb.flush;
    assign issue        = dec.valid && !stall && !sb.flush;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int unsigned r = 1; r < REG_FILE_LEN; r++) begin
            inc_vec[r] = issue && dec.writes && (dec.dst == IDX_W'(r));
            dec_vec[r] = sb.wb_valid && (sb.wb_dst == IDX_W'(r));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < REG_FILE_LEN; r++) begin
                cnt[r] <= '0;
            end
            err <= 1'b0;
        end else begin
            // Orphan writeback detection still applies in a flush cycle.
            if (sb.wb_valid && (sb.wb_dst != '0) && (cnt[sb.wb_dst] == '0)) begin
                err <= 1'b1;
            end
            for (int unsigned r = 0; r < REG_FILE_LEN; r++) begin
                if (sb.flush) begin
                    cnt[r] <= '0;
                end else if (inc_vec[r] && !dec_vec[r]) begin
                    cnt[r] <= cnt[r] + 1'b1;
                end else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0)) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        sb.busy_mask = '0;
        for (int unsigned r = 0; r < REG_FILE_LEN; r++) begin
            sb.busy_mask[r] = (cnt[r] != '0);
        end
    end

    assign sb.stall_out = stall;
    assign sb.issue_out = issue;
    assign sb.sel_src1  = sel1;
    assign sb.sel_src2  = sel2;
    assign sb.err_out   = err;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard: hand-computed expected
// stall/issue/select/busy/error values over a linear stimulus sequence.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_FILE_LEN(32)) sb ();

    hazard_scoreboard #(.REG_FILE_LEN(32), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic v, input logic [4:0] s1, input logic u1,
                           input logic [4:0] s2, input logic u2,
                           input logic [4:0] d, input logic w);
        sb.dec_valid     = v;
        sb.dec_src1      = s1;
        sb.dec_src1_used = u1;
        sb.dec_src2      = s2;
        sb.dec_src2_used = u2;
        sb.dec_dst       = d;
        sb.dec_writes    = w;
    endtask

    task automatic set_exe(input logic v, input logic w, input logic [4:0] d, input logic r);
        sb.exe_valid = v;
        sb.exe_wen   = w;
        sb.exe_dst   = d;
        sb.exe_ready = r;
    endtask

    task automatic set_mem(input logic v, input logic w, input logic [4:0] d, input logic r);
        sb.mem_valid = v;
        sb.mem_wen   = w;
        sb.mem_dst   = d;
        sb.mem_ready = r;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] d);
        sb.wb_valid = v;
        sb.wb_dst   = d;
    endtask

    initial begin
        set_dec(0, 0, 0, 0, 0, 0, 0);
        set_exe(0, 0, 0, 0);
        set_mem(0, 0, 0, 0);
        set_wb(0, 0);
        sb.flush = 1'b0;

        // Reset state and combinational decisions during reset
        #2 rst = 1'b0;
        #1;
        check("rst_busy",  sb.busy_mask, 32'h0);
        check("rst_err",   sb.err_out,   1'b0);
        check("rst_stall", sb.stall_out, 1'b0);
        check("rst_issue", sb.issue_out, 1'b0);
        set_dec(1, 1, 1, 2, 1, 5, 1);
        #1;
        check("rst_issue_comb", sb.issue_out, 1'b1);
        set_dec(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b1;

        // Independent instructions back to back
        set_dec(1, 1, 1, 2, 1, 5, 1);
        #1;
        check("ind1_stall", sb.stall_out, 1'b0);
        check("ind1_issue", sb.issue_out, 1'b1);
        check("ind1_sel1",  sb.sel_src1,  2'b00);
        check("ind1_sel2",  sb.sel_src2,  2'b00);
        tick();
        set_dec(1, 3, 1, 4, 1, 6, 1);
        #1;
        check("ind2_issue", sb.issue_out, 1'b1);
        check("ind2_busy",  sb.busy_mask, 32'h20);
        tick();
        check("ind_busy", sb.busy_mask, 32'h60);

        // EXE bypass of x5
        set_dec(1, 5, 1, 0, 0, 8, 1);
        set_exe(1, 1, 5, 1);
        #1;
        check("exe_sel1",  sb.sel_src1,  2'b01);
        check("exe_issue", sb.issue_out, 1'b1);
        tick();
        set_exe(0, 0, 0, 0);

        // WB bypass on x5; x6 in flight without bypass blocks
        set_dec(1, 5, 1, 6, 1, 0, 0);
        set_wb(1, 5);
        #1;
        check("wb_sel1",     sb.sel_src1,  2'b11);
        check("nobyp_stall", sb.stall_out, 1'b1);
        check("nobyp_issue", sb.issue_out, 1'b0);
        tick();
        set_dec(0, 0, 0, 0, 0, 0, 0);
        set_wb(1, 6);
        tick();
        set_wb(1, 8);
        tick();
        set_wb(0, 0);
        #1;
        check("drain_busy", sb.busy_mask, 32'h0);
        check("drain_err",  sb.err_out,   1'b0);

        // Load-use on x7
        set_dec(1, 0, 0, 0, 0, 7, 1);
        tick();
        set_dec(1, 7, 1, 0, 0, 0, 0);
        set_mem(1, 1, 7, 0);
        #1;
        check("lu_stall", sb.stall_out, 1'b1);
        check("lu_issue", sb.issue_out, 1'b0);
        tick();
        sb.mem_ready = 1'b1;
        #1;
        check("lu_sel1",   sb.sel_src1,  2'b10);
        check("lu_stall2", sb.stall_out, 1'b0);
        check("lu_issue2", sb.issue_out, 1'b1);
        set_exe(1, 1, 7, 0);
        #1;
        check("youngest_stall", sb.stall_out, 1'b1);
        set_exe(0, 0, 0, 0);
        set_mem(0, 0, 0, 0);
        set_dec(0, 0, 0, 0, 0, 0, 0);
        set_wb(1, 7);
        tick();
        set_wb(0, 0);

        // Counter saturation on x9
        set_dec(1, 0, 0, 0, 0, 9, 1);
        tick();
        tick();
        tick();
        check("sat_stall", sb.stall_out, 1'b1);
        check("sat_issue", sb.issue_out, 1'b0);
        check("sat_busy",  sb.busy_mask, 32'h200);
        set_wb(1, 9);
        #1;
        check("sat_wb_stall", sb.stall_out, 1'b1);
        tick();
        set_wb(0, 0);
        #1;
        check("sat_resume_stall", sb.stall_out, 1'b0);
        check("sat_resume_issue", sb.issue_out, 1'b1);
        tick();

        // Simultaneous issue and writeback on x4, then with flush
        set_dec(1, 0, 0, 0, 0, 4, 1);
        tick();
        check("x4_busy", sb.busy_mask, 32'h210);
        set_wb(1, 4);
        #1;
        check("x4_incdec_issue", sb.issue_out, 1'b1);
        tick();
        check("x4_incdec_busy", sb.busy_mask, 32'h210);
        sb.flush = 1'b1;
        #1;
        check("flush_issue", sb.issue_out, 1'b0);
        check("flush_stall", sb.stall_out, 1'b0);
        tick();
        sb.flush = 1'b0;
        set_dec(0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 0);
        #1;
        check("flush_busy", sb.busy_mask, 32'h0);
        check("flush_err",  sb.err_out,   1'b0);

        // Orphan writeback sets a sticky error
        set_wb(1, 12);
        tick();
        set_wb(0, 0);
        #1;
        check("orphan_err", sb.err_out, 1'b1);
        tick();
        check("orphan_err_sticky", sb.err_out, 1'b1);

        // x0 reads and writes are never tracked
        set_dec(1, 0, 1, 0, 1, 0, 1);
        set_exe(1, 1, 0, 0);
        #1;
        check("x0_sel1",  sb.sel_src1,  2'b00);
        check("x0_sel2",  sb.sel_src2,  2'b00);
        check("x0_stall", sb.stall_out, 1'b0);
        check("x0_issue", sb.issue_out, 1'b1);
        tick();
        set_exe(0, 0, 0, 0);
        set_dec(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("x0_busy", sb.busy_mask, 32'h0);

        // Asynchronous reset mid-stream
        set_dec(1, 0, 0, 0, 0, 3, 1);
        tick();
        set_dec(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("pre_rst_busy", sb.busy_mask, 32'h8);
        check("pre_rst_err",  sb.err_out,   1'b1);
        rst = 1'b0;
        #1;
        check("async_rst_busy", sb.busy_mask, 32'h0);
        check("async_rst_err",  sb.err_out,   1'b0);
        tick();
        rst = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
